seg7_scan_driver: RTL and testbench

Time-multiplexed two-digit seven-segment display driver that consumes the `display_led` countdown bus produced by the traffic-light controller and drives a physical common-anode LED panel. Each frame it snapshots both digits, decodes them to segment patterns, and scans the tens and ones digits in turn with a dead-time blanking slot between them to prevent ghosting. It sits between the traffic-light core and the board pins, sharing the core's clock, reset and enable.

---
 rtl/seg7_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver for a common-anode panel.
// Each frame snapshots the tens/ones nibbles of display_led and scans
// blank -> tens -> blank -> ones. The blank slots provide dead time between
// digit selects.
// Optional build macro: SEG7_LZ_SUPPRESS_EN blanks a leading tens zero.
module seg7_scan_driver #(
    parameter int unsigned pSCAN_CNT_VALUE = 99,
    parameter int unsigned pBLANK_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0][7:0] display_led,
    output logic [6:0]      seg_n,
    output logic [1:0]      dig_n,
    output logic            frame_start
);

    localparam int unsigned ShowLen  = pSCAN_CNT_VALUE + 1;
    localparam int unsigned BlankLen = pBLANK_CYCLES;
    localparam int unsigned MaxLen   = (ShowLen > BlankLen) ? ShowLen : BlankLen;
    localparam int unsigned CntW     = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    localparam logic [CntW-1:0] ShowLast  = CntW'(ShowLen - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankLen - 1);

    localparam logic [6:0] SegBlank = 7'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StBlankT,
        StShowT,
        StBlankO,
        StShowO
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      tens_q, ones_q;
    logic            capture;
    logic [6:0]      seg_d;
    logic [1:0]      dig_d;
    logic            frame_start_d;

    // Active-low segment decode; nibbles above 9 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    // Next-state, slot counter and snapshot capture strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        capture = 1'b0;
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlankT;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
                StBlankT: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShowT;
                        cnt_d   = '0;
                    end
                end
                StShowT: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StBlankO;
                        cnt_d   = '0;
                    end
                end
                StBlankO: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShowO;
                        cnt_d   = '0;
                    end
                end
                StShowO: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StBlankT;
                        cnt_d   = '0;
                        capture = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pin values derived from the current state; registered one cycle later.
    always_comb begin
        seg_d         = SegBlank;
        dig_d         = 2'b11;
        frame_start_d = (state_q == StBlankT) && (cnt_q == '0);
        unique case (state_q)
            StShowT: begin
`ifdef SEG7_LZ_SUPPRESS_EN
                if (tens_q != 4'd0) begin
                    dig_d = 2'b01;
                    seg_d = decode(tens_q);
                end
`else
                dig_d = 2'b01;
                seg_d = decode(tens_q);
`endif
            end
            StShowO: begin
                dig_d = 2'b10;
                seg_d = decode(ones_q);
            end
            default: ;
        endcase
    end

    // Scanner state, slot counter and per-frame digit snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                tens_q <= display_led[1][3:0];
                ones_q <= display_led[0][3:0];
            end
        end
    end

    // Registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n       <= SegBlank;
            dig_n       <= 2'b11;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= seg_d;
            dig_n       <= dig_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with S=10, B=2 (24-cycle frame).
module tb_seg7_scan_driver;

    localparam int unsigned S = 10;
    localparam int unsigned B = 2;
    localparam int unsigned Period = 2 * (B + S);

`ifdef SEG7_LZ_SUPPRESS_EN
    localparam logic [1:0] TensZeroDig = 2'b11;
    localparam logic [6:0] TensZeroSeg = 7'h7F;
`else
    localparam logic [1:0] TensZeroDig = 2'b01;
    localparam logic [6:0] TensZeroSeg = 7'h40;
`endif

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [1:0][7:0] display_led;
    logic [6:0]      seg_n;
    logic [1:0]      dig_n;
    logic            frame_start;

    int vectors;
    int miscompares;

    seg7_scan_driver #(
        .pSCAN_CNT_VALUE(S - 1),
        .pBLANK_CYCLES  (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .display_led(display_led),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {frame_start, dig_n, seg_n} at frame position i (0 = first pin cycle).
    function automatic logic [9:0] exp_pins(input int i, input logic [1:0] tdig,
                                            input logic [6:0] tseg, input logic [6:0] oseg);
        if (i < int'(B))            return {(i == 0), 2'b11, 7'h7F};
        else if (i < int'(B + S))   return {1'b0, tdig, tseg};
        else if (i < int'(2*B + S)) return {1'b0, 2'b11, 7'h7F};
        else                        return {1'b0, 2'b10, oseg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise en with new data; returns just after the capture edge.
    task automatic start_scan(input logic [7:0] tens, input logic [7:0] ones);
        display_led = {tens, ones};
        en = 1'b1;
        tick();
    endtask

    task automatic go_idle();
        en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b1;
        en = 1'b0;
        display_led = '0;
        #2 rst_n = 1'b0;
        #1;
        got = {frame_start, dig_n, seg_n};
        vectors++;
        if (got !== {1'b0, 2'b11, 7'h7F}) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", got, {1'b0, 2'b11, 7'h7F});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {frame_start, dig_n, seg_n};
            vectors++;
            if (got !== {1'b0, 2'b11, 7'h7F}) begin
                miscompares++;
                $display("FAIL idle_after_reset i=%0d got %h want %h", i, got,
                         {1'b0, 2'b11, 7'h7F});
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [9:0] got, want;
        start_scan(8'd1, 8'd7);
        for (int i = 0; i < 2 * int'(Period); i++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = exp_pins(i % int'(Period), 2'b01, 7'h79, 7'h78);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL basic_scan i=%0d got %h want %h", i, got, want);
            end
        end
        go_idle();
    endtask

    task automatic test_snapshot();
        logic [9:0] got, want;
        start_scan(8'd1, 8'd7);
        for (int i = 0; i < 2 * int'(Period); i++) begin
            tick();
            got = {frame_start, dig_n, seg_n};
            if (i < int'(Period)) want = exp_pins(i, 2'b01, 7'h79, 7'h78);
            else want = exp_pins(i - int'(Period), TensZeroDig, TensZeroSeg, 7'h19);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL snapshot i=%0d got %h want %h", i, got, want);
            end
            if (i == 5) display_led = {8'd0, 8'd4};
        end
        go_idle();
    endtask

    task automatic test_decode_edges();
        logic [9:0] got, want;
        start_scan(8'h3A, 8'h35);
        for (int i = 0; i < int'(Period); i++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = exp_pins(i, 2'b01, 7'h3F, 7'h12);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL decode_edges i=%0d got %h want %h", i, got, want);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        logic [9:0] got, want;
        start_scan(8'd2, 8'd3);
        for (int i = 0; i <= 16; i++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = exp_pins(i, 2'b01, 7'h24, 7'h30);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL en_drop_pre i=%0d got %h want %h", i, got, want);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = (k == 0) ? {1'b0, 2'b10, 7'h30} : {1'b0, 2'b11, 7'h7F};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL en_drop_blank k=%0d got %h want %h", k, got, want);
            end
        end
        start_scan(8'd9, 8'd8);
        got = {frame_start, dig_n, seg_n};
        vectors++;
        if (got !== {1'b0, 2'b11, 7'h7F}) begin
            miscompares++;
            $display("FAIL en_drop_capture_edge got %h want %h", got, {1'b0, 2'b11, 7'h7F});
        end
        for (int i = 0; i < int'(Period); i++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = exp_pins(i, 2'b01, 7'h10, 7'h00);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL en_drop_restart i=%0d got %h want %h", i, got, want);
            end
        end
        go_idle();
    endtask

    task automatic test_async_reset_idle();
        logic [9:0] got;
        start_scan(8'd1, 8'd7);
        repeat (6) tick();
        got = {frame_start, dig_n, seg_n};
        vectors++;
        if (got !== {1'b0, 2'b01, 7'h79}) begin
            miscompares++;
            $display("FAIL pre_reset_show got %h want %h", got, {1'b0, 2'b01, 7'h79});
        end
        #2 rst_n = 1'b0;
        #1;
        got = {frame_start, dig_n, seg_n};
        vectors++;
        if (got !== {1'b0, 2'b11, 7'h7F}) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", got, {1'b0, 2'b11, 7'h7F});
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            got = {frame_start, dig_n, seg_n};
            vectors++;
            if (got !== {1'b0, 2'b11, 7'h7F}) begin
                miscompares++;
                $display("FAIL idle_hold i=%0d got %h want %h", i, got, {1'b0, 2'b11, 7'h7F});
            end
        end
    endtask

`ifdef SEG7_LZ_SUPPRESS_EN
    task automatic test_leading_zero();
        logic [9:0] got, want;
        start_scan(8'd0, 8'd4);
        for (int i = 0; i < int'(Period); i++) begin
            tick();
            got  = {frame_start, dig_n, seg_n};
            want = exp_pins(i, 2'b11, 7'h7F, 7'h19);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL leading_zero i=%0d got %h want %h", i, got, want);
            end
        end
        go_idle();
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_decode_edges();
        test_enable_drop();
`ifdef SEG7_LZ_SUPPRESS_EN
        test_leading_zero();
`endif
        test_async_reset_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
